// File: rtl/obi_bram_port_ctrl.sv
// Request-side controller for one port of a byte-write block RAM shared by an
// instruction-fetch manager (m0, read-only) and a load/store manager (m1).
// Arbitrates, decodes the address window, drives the RAM port and tracks the
// fixed read latency so each response returns to the manager that issued it.
module obi_bram_port_ctrl #(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             RAM_ADDR_WIDTH = 17,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter int unsigned             LATENCY        = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      m0_req_i,
    output logic                      m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    output logic                      m0_rvalid_o,
    output logic [31:0]               m0_rdata_o,
    output logic                      m0_err_o,
    input  logic                      m1_req_i,
    output logic                      m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic                      m1_we_i,
    input  logic [3:0]                m1_be_i,
    input  logic [31:0]               m1_wdata_i,
    output logic                      m1_rvalid_o,
    output logic [31:0]               m1_rdata_o,
    output logic                      m1_err_o,
    output logic                      ram_en_o,
    output logic [3:0]                ram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    output logic                      ram_regce_o,
    output logic                      ram_rst_o,
    input  logic [31:0]               ram_rdata_i
);

    typedef enum logic {
        MGR0 = 1'b0,
        MGR1 = 1'b1
    } mgr_e;

    typedef struct packed {
        logic valid;
        mgr_e id;
        logic is_write;
        logic err;
    } track_t;

    mgr_e                  last_q;
    logic                  contended;
    logic                  sel_m1;
    logic                  accepted;
    logic                  req_we;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] offset;
    logic [31:0]           rsp_data;
    track_t                next_entry;
    track_t                rsp;
    track_t [LATENCY-1:0]  stage_q;

    // Round-robin arbitration and request mux; grants are masked during reset
    always_comb begin
        contended = m0_req_i & m1_req_i;
        sel_m1    = m1_req_i & (~m0_req_i | (last_q == MGR0));
        m0_gnt_o  = rst_ni & m0_req_i & ~sel_m1;
        m1_gnt_o  = rst_ni & sel_m1;
        accepted  = m0_gnt_o | m1_gnt_o;
        req_addr  = sel_m1 ? m1_addr_i : m0_addr_i;
        req_we    = sel_m1 & m1_we_i;
        offset    = req_addr - BASE_ADDR;
        in_range  = (offset >> (RAM_ADDR_WIDTH + 2)) == '0;
    end

    // RAM port drive; everything returns to zero when nothing is accepted
    always_comb begin
        ram_en_o    = accepted & in_range;
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (accepted) begin
            ram_addr_o = offset[RAM_ADDR_WIDTH+1:2];
        end
        if (accepted && in_range && req_we) begin
            ram_we_o    = m1_be_i;
            ram_wdata_o = m1_wdata_i;
        end
    end

    // Last-winner register, updated only when both managers competed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= MGR1;
        end else if (contended) begin
            last_q <= sel_m1 ? MGR1 : MGR0;
        end
    end

    // Entry loaded into the first tracking stage
    always_comb begin
        next_entry          = '0;
        next_entry.valid    = accepted;
        next_entry.id       = sel_m1 ? MGR1 : MGR0;
        next_entry.is_write = req_we;
        next_entry.err      = ~in_range;
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            // Single tracking stage, matches a RAM without output register
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_q <= '0;
                end else begin
                    stage_q[0] <= next_entry;
                end
            end
            assign ram_regce_o = 1'b0;
        end else begin : g_latn
            // Tracking shift register, shifts every cycle unconditionally
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= {stage_q[LATENCY-2:0], next_entry};
                end
            end
            assign ram_regce_o = stage_q[0].valid & ~stage_q[0].err;
        end
    endgenerate

    assign ram_rst_o = 1'b0;

    // Response routing from the last tracking stage
    always_comb begin
        rsp         = stage_q[LATENCY-1];
        rsp_data    = (rsp.valid && !rsp.is_write && !rsp.err) ? ram_rdata_i : '0;
        m0_rvalid_o = rsp.valid & (rsp.id == MGR0);
        m1_rvalid_o = rsp.valid & (rsp.id == MGR1);
        m0_err_o    = m0_rvalid_o & rsp.err;
        m1_err_o    = m1_rvalid_o & rsp.err;
        m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
        m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;
    end

endmodule

// File: tb/tb_obi_bram_port_ctrl.sv
// Bench for obi_bram_port_ctrl: a LATENCY=2 and a LATENCY=1 instance share
// the same manager stimulus, each with its own write-first RAM model.
module tb_obi_bram_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m1_req, m1_we;
    logic [31:0] m0_addr, m1_addr, m1_wdata;
    logic [3:0]  m1_be;

    logic        m0_gnt_a, m0_rvalid_a, m0_err_a, m1_gnt_a, m1_rvalid_a, m1_err_a;
    logic [31:0] m0_rdata_a, m1_rdata_a, ram_wdata_a, ram_rdata_a;
    logic        ram_en_a, ram_regce_a, ram_rst_a;
    logic [3:0]  ram_we_a;
    logic [16:0] ram_addr_a;

    logic        m0_gnt_b, m0_rvalid_b, m0_err_b, m1_gnt_b, m1_rvalid_b, m1_err_b;
    logic [31:0] m0_rdata_b, m1_rdata_b, ram_wdata_b, ram_rdata_b;
    logic        ram_en_b, ram_regce_b, ram_rst_b;
    logic [3:0]  ram_we_b;
    logic [16:0] ram_addr_b;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    obi_bram_port_ctrl #(
        .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .BASE_ADDR(32'h0000_0000), .LATENCY(2)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt_a), .m0_addr_i(m0_addr),
        .m0_rvalid_o(m0_rvalid_a), .m0_rdata_o(m0_rdata_a), .m0_err_o(m0_err_a),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt_a), .m1_addr_i(m1_addr),
        .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
        .m1_rvalid_o(m1_rvalid_a), .m1_rdata_o(m1_rdata_a), .m1_err_o(m1_err_a),
        .ram_en_o(ram_en_a), .ram_we_o(ram_we_a), .ram_addr_o(ram_addr_a),
        .ram_wdata_o(ram_wdata_a), .ram_regce_o(ram_regce_a), .ram_rst_o(ram_rst_a),
        .ram_rdata_i(ram_rdata_a)
    );

    obi_bram_port_ctrl #(
        .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .BASE_ADDR(32'h0000_0000), .LATENCY(1)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt_b), .m0_addr_i(m0_addr),
        .m0_rvalid_o(m0_rvalid_b), .m0_rdata_o(m0_rdata_b), .m0_err_o(m0_err_b),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt_b), .m1_addr_i(m1_addr),
        .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
        .m1_rvalid_o(m1_rvalid_b), .m1_rdata_o(m1_rdata_b), .m1_err_o(m1_err_b),
        .ram_en_o(ram_en_b), .ram_we_o(ram_we_b), .ram_addr_o(ram_addr_b),
        .ram_wdata_o(ram_wdata_b), .ram_regce_o(ram_regce_b), .ram_rst_o(ram_rst_b),
        .ram_rdata_i(ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first RAM models, 256 words, initial word k = 32'hA500_0000 | k
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] dout1_a, dout2_a, dout1_b;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'hA500_0000 | i;
            mem_b[i] = 32'hA500_0000 | i;
        end
    end

    always @(posedge clk) begin
        if (ram_en_a) begin
            mem_a[ram_addr_a[7:0]] <= merge(mem_a[ram_addr_a[7:0]], ram_wdata_a, ram_we_a);
            dout1_a                <= merge(mem_a[ram_addr_a[7:0]], ram_wdata_a, ram_we_a);
        end
        if (ram_rst_a)        dout2_a <= '0;
        else if (ram_regce_a) dout2_a <= dout1_a;
        if (ram_en_b) begin
            mem_b[ram_addr_b[7:0]] <= merge(mem_b[ram_addr_b[7:0]], ram_wdata_b, ram_we_b);
            dout1_b                <= merge(mem_b[ram_addr_b[7:0]], ram_wdata_b, ram_we_b);
        end
    end

    assign ram_rdata_a = dout2_a;
    assign ram_rdata_b = dout1_b;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic [31:0] m1_addr;
        logic        m1_we;
        logic [3:0]  m1_be;
        logic [31:0] m1_wdata;
        logic [1:0]  x_gnt;    // {m1, m0}
        logic        x_en;
        logic [3:0]  x_we;
        logic [16:0] x_addr;
        logic [31:0] x_wdata;
        logic [1:0]  x_rv;     // {m1, m0}
        logic [1:0]  x_err;    // {m1, m0}
        logic [31:0] x_rd0;
        logic [31:0] x_rd1;
    } vec_t;

    function automatic vec_t idle(input logic [1:0] rv, input logic [1:0] err,
                                  input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v = '{1'b0, '0, 1'b0, '0, 1'b0, 4'h0, '0, 2'b00, 1'b0, 4'h0, '0, '0, rv, err, rd0, rd1};
        return v;
    endfunction

    vec_t vecs [17];

    initial begin
        logic [127:0] act, exp;

        // Responses for a grant in row i appear in row i+2 (LATENCY=2 instance)
        vecs[0]  = '{1'b0, '0, 1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF,
                     2'b10, 1'b1, 4'hF, 17'd4, 32'hDEADBEEF, 2'b00, 2'b00, '0, '0};
        vecs[1]  = '{1'b1, 32'h10, 1'b0, '0, 1'b0, 4'h0, '0,
                     2'b01, 1'b1, 4'h0, 17'd4, '0, 2'b00, 2'b00, '0, '0};
        vecs[2]  = '{1'b0, '0, 1'b1, 32'h10, 1'b1, 4'b0010, 32'h0000AB00,
                     2'b10, 1'b1, 4'b0010, 17'd4, 32'h0000AB00, 2'b10, 2'b00, '0, '0};
        vecs[3]  = '{1'b0, '0, 1'b1, 32'h10, 1'b0, 4'h0, '0,
                     2'b10, 1'b1, 4'h0, 17'd4, '0, 2'b01, 2'b00, 32'hDEADBEEF, '0};
        vecs[4]  = idle(2'b10, 2'b00, '0, '0);
        vecs[5]  = idle(2'b10, 2'b00, '0, 32'hDEADABEF);
        vecs[6]  = '{1'b1, 32'h20, 1'b1, 32'h24, 1'b0, 4'h0, '0,
                     2'b01, 1'b1, 4'h0, 17'd8, '0, 2'b00, 2'b00, '0, '0};
        vecs[7]  = '{1'b1, 32'h20, 1'b1, 32'h24, 1'b0, 4'h0, '0,
                     2'b10, 1'b1, 4'h0, 17'd9, '0, 2'b00, 2'b00, '0, '0};
        vecs[8]  = '{1'b1, 32'h20, 1'b1, 32'h24, 1'b0, 4'h0, '0,
                     2'b01, 1'b1, 4'h0, 17'd8, '0, 2'b01, 2'b00, 32'hA500_0008, '0};
        vecs[9]  = '{1'b1, 32'h20, 1'b1, 32'h24, 1'b0, 4'h0, '0,
                     2'b10, 1'b1, 4'h0, 17'd9, '0, 2'b10, 2'b00, '0, 32'hA500_0009};
        vecs[10] = idle(2'b01, 2'b00, 32'hA500_0008, '0);
        vecs[11] = idle(2'b10, 2'b00, '0, 32'hA500_0009);
        vecs[12] = '{1'b0, '0, 1'b1, 32'h0008_0000, 1'b0, 4'h0, '0,
                     2'b10, 1'b0, 4'h0, 17'd0, '0, 2'b00, 2'b00, '0, '0};
        vecs[13] = '{1'b1, 32'h3, 1'b0, '0, 1'b0, 4'h0, '0,
                     2'b01, 1'b1, 4'h0, 17'd0, '0, 2'b00, 2'b00, '0, '0};
        vecs[14] = idle(2'b10, 2'b10, '0, '0);
        vecs[15] = idle(2'b01, 2'b00, 32'hA500_0000, '0);
        vecs[16] = idle(2'b00, 2'b00, '0, '0);

        // Reset state: requests asserted but everything forced low
        rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF;
        m0_addr = 32'h10; m1_addr = 32'h10; m1_wdata = 32'h1234_5678;
        #3;
        chk("reset_req", {m0_gnt_a, m1_gnt_a, ram_en_a, ram_we_a, m0_gnt_b, m1_gnt_b, ram_en_b}, '0);
        chk("reset_rsp", {m0_rvalid_a, m1_rvalid_a, m0_err_a, m1_err_a, m0_rdata_a, m1_rdata_a}, '0);
        m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0;
        m0_addr = '0; m1_addr = '0; m1_wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven rows on the LATENCY=2 instance
        for (int i = 0; i < 17; i++) begin
            m0_req = vecs[i].m0_req;  m0_addr = vecs[i].m0_addr;
            m1_req = vecs[i].m1_req;  m1_addr = vecs[i].m1_addr;
            m1_we  = vecs[i].m1_we;   m1_be   = vecs[i].m1_be;   m1_wdata = vecs[i].m1_wdata;
            #4;
            act = {m1_gnt_a, m0_gnt_a, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a};
            exp = {vecs[i].x_gnt, vecs[i].x_en, vecs[i].x_we, vecs[i].x_addr, vecs[i].x_wdata};
            chk($sformatf("row%0d_req", i), act, exp);
            act = {m1_rvalid_a, m0_rvalid_a,
                   vecs[i].x_rv[1] ? m1_err_a : 1'b0, vecs[i].x_rv[0] ? m0_err_a : 1'b0,
                   vecs[i].x_rv[0] ? m0_rdata_a : 32'h0, vecs[i].x_rv[1] ? m1_rdata_a : 32'h0};
            exp = {vecs[i].x_rv, vecs[i].x_err, vecs[i].x_rd0, vecs[i].x_rd1};
            chk($sformatf("row%0d_rsp", i), act, exp);
            @(posedge clk); #1;
        end

        // Back-to-back m0 burst over words 32..39, checked on both latencies
        for (int k = 0; k < 10; k++) begin
            m0_req  = (k < 8);
            m0_addr = (k < 8) ? 32'h80 + 32'(4 * k) : 32'h0;
            #4;
            chk($sformatf("burst_l1_%0d", k), {m0_rvalid_b, m0_rvalid_b ? m0_rdata_b : 32'h0},
                {(k >= 1 && k <= 8), (k >= 1 && k <= 8) ? 32'hA500_0020 + 32'(k - 1) : 32'h0});
            chk($sformatf("burst_l2_%0d", k), {m0_rvalid_a, m0_rvalid_a ? m0_rdata_a : 32'h0},
                {(k >= 2 && k <= 9), (k >= 2 && k <= 9) ? 32'hA500_0020 + 32'(k - 2) : 32'h0});
            if (k == 3) chk("l1_regce_tied", {ram_regce_b, ram_rst_b, ram_rst_a}, '0);
            @(posedge clk); #1;
        end

        // Reset with two reads in flight
        m0_req = 1'b1; m0_addr = 32'h4;
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h8;
        @(posedge clk); #1;
        m1_req = 1'b0;
        #1;
        chk("pre_rst_rsp", {m0_rvalid_a, m0_rdata_a}, {1'b1, 32'hA500_0001});
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {m0_rvalid_a, m1_rvalid_a, m0_rvalid_b, m1_rvalid_b,
                          m0_gnt_a, m1_gnt_a, ram_en_a, ram_we_a}, '0);
        m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk($sformatf("post_rst_quiet%0d", k),
                {m0_rvalid_a, m1_rvalid_a, m0_rvalid_b, m1_rvalid_b}, '0);
            @(posedge clk); #1;
        end
        m1_req = 1'b1; m1_addr = 32'h14;
        #4;
        chk("post_rst_gnt", {m1_gnt_a, ram_en_a, ram_addr_a}, {1'b1, 1'b1, 17'd5});
        @(posedge clk); #1;
        m1_req = 1'b0;
        #4;
        chk("post_rst_l1", {m1_rvalid_b, m1_rdata_b, m1_rvalid_a}, {1'b1, 32'hA500_0005, 1'b0});
        @(posedge clk); #1;
        #4;
        chk("post_rst_l2", {m1_rvalid_a, m1_rdata_a, m1_rvalid_b}, {1'b1, 32'hA500_0005, 1'b0});
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
